// File: rtl/channel_mux_8x1.sv
// channel_mux_8x1: eight 8-bit request channels arbitrated round-robin into a
// single registered output stage with a valid/ready handshake downstream.
// A grant consumes the channel word at the same edge that loads it into dout,
// so a word appears on dout one cycle after its request wins arbitration.
module channel_mux_8x1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    input  logic [7:0] e,
    input  logic [7:0] f,
    input  logic [7:0] g,
    input  logic [7:0] h,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [7:0] dout,
    output logic [2:0] sel,
    output logic       dout_valid,
    input  logic       dout_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] ptr;
    logic       pop;
    logic       load_ok;
    logic       found;
    logic [2:0] grant_idx;
    logic       grant;
    logic [7:0] ch_word;

    // The output register frees up either when it is empty or when its word
    // leaves this cycle, which is what allows one word per cycle.
    assign pop        = (state_q == FULL) && dout_ready;
    assign load_ok    = (state_q == EMPTY) || pop;
    assign dout_valid = (state_q == FULL);

    // Round-robin search: first requesting channel at or after ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the tool infers a latch to hold the old value.
        found     = 1'b0;
        grant_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[ptr + 3'(i)]) begin
                found     = 1'b1;
                grant_idx = ptr + 3'(i);
            end
        end
    end

    // Grant is combinational so the upstream sees it in the consuming cycle;
    // reset masks it so nothing is consumed while the block is held in reset.
    always_comb begin
        gnt = 8'h00;
        if (load_ok && found && !rst) begin
            gnt = 8'(1) << grant_idx;
        end
    end

    assign grant = |gnt;

    // Select the granted channel's data for loading into dout.
    always_comb begin
        ch_word = a;
        case (grant_idx)
            3'd0: ch_word = a;
            3'd1: ch_word = b;
            3'd2: ch_word = c;
            3'd3: ch_word = d;
            3'd4: ch_word = e;
            3'd5: ch_word = f;
            3'd6: ch_word = g;
            3'd7: ch_word = h;
            default: ch_word = a;
        endcase
    end

    // FSM next state: a grant always fills the register; a pop alone drains it.
    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = FULL;
        end else if (pop) begin
            state_d = EMPTY;
        end
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word, source index and priority pointer update only on a grant;
    // on a drain they keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
            sel  <= 3'd0;
            ptr  <= 3'd0;
        end else if (grant) begin
            dout <= ch_word;
            sel  <= grant_idx;
            ptr  <= grant_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_channel_mux_8x1.sv
// Self-checking bench for channel_mux_8x1: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// arbiter/output register kept in plain integers.
module tb_channel_mux_8x1;

    logic       clk;
    logic       rst;
    logic [7:0] ch [8];
    logic [7:0] req;
    logic [7:0] gnt;
    logic [7:0] dout;
    logic [2:0] sel;
    logic       dout_valid;
    logic       dout_ready;

    int vectors;
    int miscompares;

    // Behavioural model state.
    bit         m_full;
    int         m_ptr;
    logic [7:0] m_dout;
    int         m_sel;
    logic [7:0] last_gnt;

    channel_mux_8x1 dut (
        .clk        (clk),
        .rst        (rst),
        .a          (ch[0]),
        .b          (ch[1]),
        .c          (ch[2]),
        .d          (ch[3]),
        .e          (ch[4]),
        .f          (ch[5]),
        .g          (ch[6]),
        .h          (ch[7]),
        .req        (req),
        .gnt        (gnt),
        .dout       (dout),
        .sel        (sel),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check gnt before the edge, advance the
    // model at the edge, check the registered outputs just after it.
    task automatic cycle(input logic r, input logic [7:0] rq, input logic rdy);
        logic [7:0] exp_gnt;
        int         k;
        rst        = r;
        req        = rq;
        dout_ready = rdy;
        #2;
        exp_gnt = 8'h00;
        k       = -1;
        if (!r && rq != 8'h00 && (!m_full || rdy)) begin
            for (int i = 0; i < 8; i++) begin
                if (k < 0 && rq[(m_ptr + i) % 8]) k = (m_ptr + i) % 8;
            end
            exp_gnt[k] = 1'b1;
        end
        last_gnt = gnt;
        check("gnt", gnt, exp_gnt);
        @(posedge clk);
        if (r) begin
            m_full = 0; m_ptr = 0; m_dout = 8'h00; m_sel = 0;
        end else if (k >= 0) begin
            m_full = 1; m_dout = ch[k]; m_sel = k; m_ptr = (k + 1) % 8;
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        #1;
        check("dout", dout, m_dout);
        check("sel", {5'd0, sel}, 8'(m_sel));
        check("dout_valid", {7'd0, dout_valid}, {7'd0, m_full});
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_full = 0; m_ptr = 0; m_dout = 8'h00; m_sel = 0;
        rst = 1'b1; req = 8'h00; dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) ch[i] = 8'($urandom);
        @(negedge clk);

        // Reset with every channel requesting: nothing is consumed.
        cycle(1'b1, 8'hFF, 1'b0);
        check("rst_gnt", last_gnt, 8'h00);
        cycle(1'b1, 8'hFF, 1'b1);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", {7'd0, dout_valid}, 8'h00);
        cycle(1'b0, 8'hFF, 1'b0);
        check("first_gnt", last_gnt, 8'h01);

        // Single transfer from channel 3, then confirm ptr moved to 4.
        cycle(1'b1, 8'h00, 1'b0);
        ch[3] = 8'h5A;
        cycle(1'b0, 8'h08, 1'b0);
        check("single_gnt", last_gnt, 8'h08);
        check("single_dout", dout, 8'h5A);
        check("single_sel", {5'd0, sel}, 8'd3);
        cycle(1'b0, 8'hFF, 1'b1);
        check("single_ptr", {5'd0, sel}, 8'd4);

        // Round-robin with all requesting: sel 0..7,0 back to back.
        cycle(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) ch[i] = 8'(8'h10 + i);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 8'hFF, 1'b1);
            check("rr_sel", {5'd0, sel}, 8'(i % 8));
            check("rr_valid", {7'd0, dout_valid}, 8'h01);
        end

        // Wrap: grant g sets ptr=7, then h wins before a.
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h40, 1'b1);
        cycle(1'b0, 8'h81, 1'b1);
        check("wrap_h", {5'd0, sel}, 8'd7);
        cycle(1'b0, 8'h81, 1'b1);
        check("wrap_a", {5'd0, sel}, 8'd0);

        // Backpressure: FULL, dout_ready low for 3 cycles, c waiting.
        ch[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h04, 1'b0);
            check("bp_gnt", last_gnt, 8'h00);
            check("bp_hold", {5'd0, sel}, 8'd0);
        end
        cycle(1'b0, 8'h04, 1'b1);
        check("bp_release_gnt", last_gnt, 8'h04);
        check("bp_release_dout", dout, 8'hC3);

        // Drain, then reset while FULL.
        cycle(1'b0, 8'h00, 1'b1);
        check("drain_valid", {7'd0, dout_valid}, 8'h00);
        check("drain_dout", dout, 8'hC3);
        cycle(1'b0, 8'h01, 1'b0);
        cycle(1'b1, 8'hFF, 1'b1);
        check("midrst_gnt", last_gnt, 8'h00);
        check("midrst_valid", {7'd0, dout_valid}, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) ch[i] = 8'($urandom);
            cycle(($urandom_range(0, 29) == 0), 8'($urandom) & 8'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
